ps2_kb_rx: RTL
==============

// Module: ps2_kb_rx
// PURPOSE
//  PS/2 keyboard receiver feeding the keyboard input of the CPU read-data select stage.
//  - Samples the asynchronous ps2_clk/ps2_data lines and deframes 11-bit scan-code frames.
//  - Buffers received bytes in a small FIFO.
//  - Presents the head byte on kb_data; the CPU consumes it with a read strobe.
// PARAMETERS
//  FIFO_DEPTH      16      byte entries; power of 2, >= 2
//  TIMEOUT_CYCLES  50000   clk cycles without a ps2 falling edge mid-frame before the frame is aborted
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous reset, active low
//  ps2_clk     in   1  PS/2 clock line, asynchronous to clk
//  ps2_data    in   1  PS/2 data line, asynchronous to clk
//  rd_en       in   1  pop strobe (keyboard_cs & CPU read); one pop per high cycle
//  kb_data     out  8  FIFO head byte; 8'h00 when empty
//  kb_ready    out  1  FIFO not empty
//  kb_overflow out  1  sticky: a received byte was dropped because the FIFO was full
//  frame_err   out  1  1-cycle pulse: parity or stop-bit error, frame discarded
// BEHAVIOUR
//  Clock and reset: single clock domain clk; reset is asynchronous, active low (rst_n).
//  Reset values: kb_data=0, kb_ready=0, kb_overflow=0, frame_err=0; FIFO empty; FSM IDLE.
//  Reset also clears the synchronisers and the timeout counter.
//  Input synchronisation: 2-FF synchronisers on both lines.
//  - A falling edge is a synced ps2_clk 1->0 between consecutive clk cycles.
//  - Data is sampled from synced ps2_data in the cycle the edge is detected.
//  FSM states: IDLE, DATA, PARITY, STOP.
//  - IDLE: on a falling edge with data=0 (start bit) -> DATA, bit count=0. Data=1 on an edge: ignore.
//  - DATA: shift in LSB first; after 8 bits -> PARITY.
//  - PARITY: capture the bit; check odd parity over the 8 data bits plus the parity bit -> STOP.
//  - STOP: on the edge, if stop=1 and parity good, push the byte; otherwise pulse frame_err and discard. -> IDLE.
//  Timeout: counter resets on every falling edge and counts only outside IDLE.
//  - On reaching TIMEOUT_CYCLES: -> IDLE, partial byte discarded, no frame_err.
//  Latency: the pushed byte is visible (kb_ready=1, kb_data valid) on the cycle after the stop-bit edge is detected.
//  FIFO: first-word-fall-through; pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
//  - rd_en while empty: ignored, no state change.
//  - Push while full without a same-cycle pop: byte dropped, kb_overflow<=1.
//  - Push and pop in the same cycle: both happen, including when full; no overflow.
//  - kb_overflow clears only on reset.
//  Reset mid-frame or with data buffered: all of it is lost immediately, asynchronously.
// CONFIGURATION
//  PS2_BREAK_FILTER_EN defined:
//  - A valid 8'hF0 byte is not pushed; a filter flag is set.
//  - The next valid byte is also not pushed, and the flag clears.
//  - An errored or timed-out frame leaves the flag unchanged.
//  - Only make codes reach the FIFO; overflow logic is unaffected.
//  PS2_BREAK_FILTER_EN undefined: every valid byte, including 8'hF0, is pushed; no filter state exists.
// TESTING
//  1. Reset, then frame 0x1C with parity=0 and stop=1 -> kb_ready=1 and kb_data=8'h1C one clk after the stop edge;
//     rd_en 1 cycle -> kb_ready=0, kb_data=0.
//  2. Frame 0x1C with parity=1 -> frame_err pulses for exactly 1 cycle; kb_ready stays 0.
//     Same byte with stop=0 -> same result.
//  3. 17 good frames 0x01..0x11 without reads (FIFO_DEPTH=16) -> kb_overflow=1.
//     Sixteen pops return 0x01..0x10 in order; after them kb_ready=0.
//  4. FIFO full, and rd_en coincides with the stop edge of 0x22 -> no overflow.
//     Count stays 16; 0x22 is the last byte popped.
//  5. Send start + 4 bits, then idle > TIMEOUT_CYCLES, then a good frame 0x5A -> only 0x5A is queued; no frame_err.
//  6. Sequence 0x1C, 0xF0, 0x1C:
//     - with PS2_BREAK_FILTER_EN -> FIFO holds only 0x1C.
//     - without it -> FIFO holds 0x1C, 0xF0, 0x1C.
//     Also: assert rst_n low mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: synchronises ps2_clk/ps2_data, deframes 11-bit frames and queues bytes in a FWFT FIFO.
// Optional build macro PS2_BREAK_FILTER_EN drops 8'hF0 break prefixes and the byte that follows them.
module ps2_kb_rx #(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] kb_data,
  output logic       kb_ready,
  output logic       kb_overflow,
  output logic       frame_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  function automatic logic odd_parity_ok(input logic [7:0] i_byte, input logic i_par);
    return ^{i_byte, i_par};
  endfunction

  logic          r_clk_s1, r_clk_s2, r_clk_prev, r_dat_s1, r_dat_s2;
  logic          w_fall, w_timeout, w_frame_ok, w_frame_bad, w_push;
  state_t        r_state, w_state_nxt;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic          r_par;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr, w_wr_nxt, w_rd_nxt;
  logic          w_empty, w_full, w_pop, w_wr_en, w_ovf_set, w_ready_nxt;
  logic [7:0]    w_head_nxt, w_data_nxt;
  logic          r_kb_ready, r_ovf, r_frame_err;
  logic [7:0]    r_kb_data;

  // Two-flop synchronisers plus a delayed copy of the clock line for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1   <= 1'b0;
      r_clk_s2   <= 1'b0;
      r_clk_prev <= 1'b0;
      r_dat_s1   <= 1'b0;
      r_dat_s2   <= 1'b0;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall    = r_clk_prev & ~r_clk_s2;
  assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == TO_LIMIT);

  // Mid-frame watchdog: restarts on every falling edge, idle while waiting for a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if ((r_state == ST_IDLE) || w_fall) begin
      r_to_cnt <= '0;
    end else if (!w_timeout) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and frame verdict
  always_comb begin
    w_state_nxt = r_state;
    w_frame_ok  = 1'b0;
    w_frame_bad = 1'b0;
    if (w_fall) begin
      case (r_state)
        ST_IDLE: begin
          if (!r_dat_s2) begin
            w_state_nxt = ST_DATA;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_DATA: begin
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = ST_PARITY;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
        ST_PARITY: w_state_nxt = ST_STOP;
        ST_STOP: begin
          w_state_nxt = ST_IDLE;
          if (r_dat_s2 && odd_parity_ok(r_shift, r_par)) begin
            w_frame_ok = 1'b1;
          end else begin
            w_frame_bad = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_nxt = ST_IDLE;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Bit shifter: LSB arrives first, so shift right and insert at the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_par     <= 1'b0;
    end else if (w_fall) begin
      case (r_state)
        ST_IDLE: r_bit_cnt <= 3'd0;
        ST_DATA: begin
          r_shift   <= {r_dat_s2, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        ST_PARITY: r_par <= r_dat_s2;
        default: r_par <= r_par;
      endcase
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  logic r_brk;
  assign w_push = w_frame_ok & ~r_brk & (r_shift != 8'hF0);

  // Break flag: set by F0, consumed by the key code that follows it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_brk <= 1'b0;
    end else if (w_frame_ok) begin
      if (r_brk) begin
        r_brk <= 1'b0;
      end else if (r_shift == 8'hF0) begin
        r_brk <= 1'b1;
      end
    end
  end
`else
  assign w_push = w_frame_ok;
`endif

  // FIFO control; outputs are computed from next-cycle pointers so they can be registered
  always_comb begin
    w_empty     = (r_wr_ptr == r_rd_ptr);
    w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_pop       = rd_en & ~w_empty;
    w_wr_en     = w_push & (~w_full | w_pop);
    w_ovf_set   = w_push & w_full & ~w_pop;
    w_wr_nxt    = r_wr_ptr + (AW+1)'(w_wr_en);
    w_rd_nxt    = r_rd_ptr + (AW+1)'(w_pop);
    w_ready_nxt = (w_wr_nxt != w_rd_nxt);
    if (w_wr_en && (r_wr_ptr[AW-1:0] == w_rd_nxt[AW-1:0])) begin
      w_head_nxt = r_shift;
    end else begin
      w_head_nxt = r_mem[w_rd_nxt[AW-1:0]];
    end
    if (w_ready_nxt) begin
      w_data_nxt = w_head_nxt;
    end else begin
      w_data_nxt = 8'h00;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
    end
  end

  // Pointers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_kb_ready  <= 1'b0;
      r_kb_data   <= 8'h00;
      r_ovf       <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_nxt;
      r_rd_ptr    <= w_rd_nxt;
      r_kb_ready  <= w_ready_nxt;
      r_kb_data   <= w_data_nxt;
      r_ovf       <= r_ovf | w_ovf_set;
      r_frame_err <= w_frame_bad;
    end
  end

  assign kb_data     = r_kb_data;
  assign kb_ready    = r_kb_ready;
  assign kb_overflow = r_ovf;
  assign frame_err   = r_frame_err;
endmodule
